// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared 800x600@72 timing constants, pattern-mode encoding and
//               colour-bar palette for the VGA pixel pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_RES = 800;
    localparam int V_RES = 600;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_BOX   = 2'd3
    } mode_e;

    // {red, green, blue} on/off flags, left to right across the screen
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

endpackage
`default_nettype wire

// File: rtl/vga_bounce_box.sv
`default_nettype none
// ============================================================================
// Module      : vga_bounce_box
// Description : Box position that bounces off the screen edges, stepping once
//               per frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_bounce_box #(
    parameter int H_RES    = 800,
    parameter int V_RES    = 600,
    parameter int BOX_SIZE = 16,
    parameter int BOX_STEP = 2
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        frameStartIn,
    output logic [15:0] boxXOut,
    output logic [15:0] boxYOut
);

    localparam logic [15:0] c_xLimit = 16'(H_RES - BOX_SIZE);
    localparam logic [15:0] c_yLimit = 16'(V_RES - BOX_SIZE);
    localparam logic [15:0] c_step   = 16'(BOX_STEP);

    // Returns {newIsBack, newPos}; clamps at either edge and flips direction.
    function automatic logic [16:0] stepAxis(input logic [15:0] pos,
                                             input logic        isBack,
                                             input logic [15:0] limit);
        logic [15:0] fwd;
        fwd = pos + c_step;
        if (!isBack) begin
            if (fwd > limit) stepAxis = {1'b1, limit};
            else             stepAxis = {1'b0, fwd};
        end else if (pos < c_step) begin
            stepAxis = {1'b0, 16'd0};
        end else begin
            stepAxis = {1'b1, pos - c_step};
        end
    endfunction

    logic [15:0] r_boxX;
    logic [15:0] r_boxY;
    logic        r_xBack;
    logic        r_yBack;
    logic [16:0] w_xNext;
    logic [16:0] w_yNext;

    assign w_xNext = stepAxis(r_boxX, r_xBack, c_xLimit);
    assign w_yNext = stepAxis(r_boxY, r_yBack, c_yLimit);

    // The frame-start pixel already sees the updated position.
    assign boxXOut = frameStartIn ? w_xNext[15:0] : r_boxX;
    assign boxYOut = frameStartIn ? w_yNext[15:0] : r_boxY;

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_boxX  <= 16'd0;
            r_boxY  <= 16'd0;
            r_xBack <= 1'b0;
            r_yBack <= 1'b0;
        end else if (frameStartIn) begin
            r_boxX  <= w_xNext[15:0];
            r_boxY  <= w_yNext[15:0];
            r_xBack <= w_xNext[16];
            r_yBack <= w_yNext[16];
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_test_pattern_gen
// Description : Two-stage RGB test-pattern generator (bars, checkerboard,
//               grey ramp, bouncing box) with frame-aligned mode switching.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_test_pattern_gen #(
    parameter int H_RES    = vga_pkg::H_RES,
    parameter int V_RES    = vga_pkg::V_RES,
    parameter int COLOR_W  = 4,
    parameter int BAR_W    = 100,
    parameter int BOX_SIZE = 16,
    parameter int BOX_STEP = 2
) (
    input  logic               clkIn,
    input  logic               rstIn,
    input  logic [15:0]        hPosIn,
    input  logic [15:0]        vPosIn,
    input  logic               isDisplayOnIn,
    input  logic               isHSyncIn,
    input  logic               isVSyncIn,
    input  logic               modeNextIn,
    output logic [COLOR_W-1:0] redOut,
    output logic [COLOR_W-1:0] greenOut,
    output logic [COLOR_W-1:0] blueOut,
    output logic               hSyncOut,
    output logic               vSyncOut,
    output logic [1:0]         modeOut
);
    import vga_pkg::*;

    localparam logic [15:0]        c_barW     = 16'(BAR_W);
    localparam logic [15:0]        c_boxSize  = 16'(BOX_SIZE);
    localparam logic [15:0]        c_gradMax  = 16'((1 << COLOR_W) - 1);
    localparam logic [COLOR_W-1:0] c_white    = '1;
    localparam logic [COLOR_W-1:0] c_darkBlue = c_white >> 1;

    logic               w_frameStart;
    mode_e              r_mode;
    logic               r_pending;
    mode_e              w_modeNow;
    logic [15:0]        w_boxX;
    logic [15:0]        w_boxY;
    logic [2:0]         w_barIdx;
    logic [15:0]        w_barThr;
    logic [15:0]        w_gradFull;
    logic [COLOR_W-1:0] w_grad;
    logic               w_boxHit;

    mode_e              r_s1Mode;
    logic [2:0]         r_s1BarIdx;
    logic               r_s1Checker;
    logic [COLOR_W-1:0] r_s1Grad;
    logic               r_s1BoxHit;
    logic               r_s1DispOn;
    logic               r_s1HSync;
    logic               r_s1VSync;

    logic [COLOR_W-1:0] w_red;
    logic [COLOR_W-1:0] w_green;
    logic [COLOR_W-1:0] w_blue;

    assign w_frameStart = (hPosIn == 16'd0) && (vPosIn == 16'd0);
    // A request landing on the frame-start cycle is honoured immediately.
    assign w_modeNow    = (w_frameStart && (r_pending || modeNextIn)) ?
                          mode_e'(r_mode + 2'd1) : r_mode;
    assign modeOut      = r_mode;

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_mode    <= MODE_BARS;
            r_pending <= 1'b0;
        end else begin
            r_mode <= w_modeNow;
            if (w_frameStart)    r_pending <= 1'b0;
            else if (modeNextIn) r_pending <= 1'b1;
        end
    end

    vga_bounce_box #(
        .H_RES    (H_RES),
        .V_RES    (V_RES),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box (
        .clkIn        (clkIn),
        .rstIn        (rstIn),
        .frameStartIn (w_frameStart),
        .boxXOut      (w_boxX),
        .boxYOut      (w_boxY)
    );

    // Descending threshold chain: the lowest bar whose right edge lies past hPos wins.
    always_comb begin
        w_barIdx = 3'd7;
        w_barThr = 16'(7 * BAR_W);
        for (int i = 6; i >= 0; i--) begin
            if (hPosIn < w_barThr) w_barIdx = 3'(i);
            w_barThr = w_barThr - c_barW;
        end
    end

    assign w_gradFull = hPosIn >> 6;
    assign w_grad     = (w_gradFull > c_gradMax) ? c_white : w_gradFull[COLOR_W-1:0];
    assign w_boxHit   = (hPosIn >= w_boxX) && (hPosIn < w_boxX + c_boxSize) &&
                        (vPosIn >= w_boxY) && (vPosIn < w_boxY + c_boxSize);

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_s1Mode    <= MODE_BARS;
            r_s1BarIdx  <= 3'd0;
            r_s1Checker <= 1'b0;
            r_s1Grad    <= '0;
            r_s1BoxHit  <= 1'b0;
            r_s1DispOn  <= 1'b0;
            r_s1HSync   <= 1'b0;
            r_s1VSync   <= 1'b0;
        end else begin
            r_s1Mode    <= w_modeNow;
            r_s1BarIdx  <= w_barIdx;
            r_s1Checker <= hPosIn[5] ^ vPosIn[5];
            r_s1Grad    <= w_grad;
            r_s1BoxHit  <= w_boxHit;
            r_s1DispOn  <= isDisplayOnIn;
            r_s1HSync   <= isHSyncIn;
            r_s1VSync   <= isVSyncIn;
        end
    end

    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        if (r_s1DispOn) begin
            unique case (r_s1Mode)
                MODE_BARS: begin
                    w_red   = {COLOR_W{BAR_RGB[r_s1BarIdx][2]}};
                    w_green = {COLOR_W{BAR_RGB[r_s1BarIdx][1]}};
                    w_blue  = {COLOR_W{BAR_RGB[r_s1BarIdx][0]}};
                end
                MODE_CHECK: begin
                    w_red   = r_s1Checker ? c_white : '0;
                    w_green = r_s1Checker ? c_white : '0;
                    w_blue  = r_s1Checker ? c_white : '0;
                end
                MODE_GRAD: begin
                    w_red   = r_s1Grad;
                    w_green = r_s1Grad;
                    w_blue  = r_s1Grad;
                end
                MODE_BOX: begin
                    w_red   = r_s1BoxHit ? c_white : '0;
                    w_green = r_s1BoxHit ? c_white : '0;
                    w_blue  = r_s1BoxHit ? c_white : c_darkBlue;
                end
            endcase
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            redOut   <= '0;
            greenOut <= '0;
            blueOut  <= '0;
            hSyncOut <= 1'b0;
            vSyncOut <= 1'b0;
        end else begin
            redOut   <= w_red;
            greenOut <= w_green;
            blueOut  <= w_blue;
            hSyncOut <= r_s1HSync;
            vSyncOut <= r_s1VSync;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_test_pattern_gen
// Description : Self-checking bench for vga_test_pattern_gen (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_test_pattern_gen;

    localparam int XLIM = 800 - 16;
    localparam int YLIM = 600 - 16;
    localparam int STEP = 2;

    logic        clkIn         = 1'b0;
    logic        rstIn         = 1'b1;
    logic [15:0] hPosIn        = 16'd500;
    logic [15:0] vPosIn        = 16'd500;
    logic        isDisplayOnIn = 1'b0;
    logic        isHSyncIn     = 1'b0;
    logic        isVSyncIn     = 1'b0;
    logic        modeNextIn    = 1'b0;
    logic [3:0]  redOut;
    logic [3:0]  greenOut;
    logic [3:0]  blueOut;
    logic        hSyncOut;
    logic        vSyncOut;
    logic [1:0]  modeOut;

    vga_test_pattern_gen dut (
        .clkIn         (clkIn),
        .rstIn         (rstIn),
        .hPosIn        (hPosIn),
        .vPosIn        (vPosIn),
        .isDisplayOnIn (isDisplayOnIn),
        .isHSyncIn     (isHSyncIn),
        .isVSyncIn     (isVSyncIn),
        .modeNextIn    (modeNextIn),
        .redOut        (redOut),
        .greenOut      (greenOut),
        .blueOut       (blueOut),
        .hSyncOut      (hSyncOut),
        .vSyncOut      (vSyncOut),
        .modeOut       (modeOut)
    );

    always #5 clkIn = ~clkIn;

    int    nTests = 0;
    int    nFail  = 0;
    bit    checkOn = 1'b0;
    int    fsCount = 0;

    // literal expectation attached to a driven pixel, {rgb, hsync, vsync}
    bit          litReq  = 1'b0;
    logic [13:0] litVal  = '0;
    string       litName = "";

    // immediate checks requested by the stimulus: kind 0 = mode only, 1 = all zero
    int          dirSeq  = 0;
    int          dirKind = 0;
    int          dirMode = 0;
    string       dirName = "";

    // model state
    int          mMode = 0;
    bit          mPend = 1'b0;
    int          mBoxX = 0;
    int          mBoxY = 0;
    bit          mXFwd = 1'b1;
    bit          mYFwd = 1'b1;
    logic [13:0] e1 = '0;
    logic [13:0] e2 = '0;
    bit          l1v = 1'b0;
    bit          l2v = 1'b0;
    logic [13:0] l1  = '0;
    logic [13:0] l2  = '0;
    string       l1n = "";
    string       l2n = "";

    function automatic logic [11:0] pixColour(int mode, int h, int v, int bx, int by);
        int idx;
        int g;
        logic [3:0] g4;
        case (mode)
            0: begin
                idx = h / 100;
                if (idx > 7) idx = 7;
                case (idx)
                    0: return 12'hFFF;
                    1: return 12'hFF0;
                    2: return 12'h0FF;
                    3: return 12'h0F0;
                    4: return 12'hF0F;
                    5: return 12'hF00;
                    6: return 12'h00F;
                    default: return 12'h000;
                endcase
            end
            1: return ((((h / 32) + (v / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
            2: begin
                g = h / 64;
                if (g > 15) g = 15;
                g4 = 4'(g);
                return {g4, g4, g4};
            end
            default: return (h >= bx && h < bx + 16 && v >= by && v < by + 16) ? 12'hFFF : 12'h007;
        endcase
    endfunction

    // Model: advances one pixel per clock and keeps a two-deep output delay line.
    initial begin
        logic [13:0] e;
        forever begin
            @(posedge clkIn or posedge rstIn);
            if (rstIn) begin
                mMode = 0; mPend = 1'b0;
                mBoxX = 0; mBoxY = 0; mXFwd = 1'b1; mYFwd = 1'b1;
                e1 = '0; e2 = '0; l1v = 1'b0; l2v = 1'b0;
            end else begin
                if (hPosIn == 0 && vPosIn == 0) begin
                    if (mPend || modeNextIn) begin
                        mMode = (mMode + 1) % 4;
                        mPend = 1'b0;
                    end
                    if (mXFwd) begin
                        if (mBoxX + STEP > XLIM) begin mBoxX = XLIM; mXFwd = 1'b0; end
                        else mBoxX = mBoxX + STEP;
                    end else begin
                        if (mBoxX < STEP) begin mBoxX = 0; mXFwd = 1'b1; end
                        else mBoxX = mBoxX - STEP;
                    end
                    if (mYFwd) begin
                        if (mBoxY + STEP > YLIM) begin mBoxY = YLIM; mYFwd = 1'b0; end
                        else mBoxY = mBoxY + STEP;
                    end else begin
                        if (mBoxY < STEP) begin mBoxY = 0; mYFwd = 1'b1; end
                        else mBoxY = mBoxY - STEP;
                    end
                end else if (modeNextIn) begin
                    mPend = 1'b1;
                end
                e[13:2] = isDisplayOnIn ? pixColour(mMode, int'(hPosIn), int'(vPosIn), mBoxX, mBoxY) : 12'h000;
                e[1]    = isHSyncIn;
                e[0]    = isVSyncIn;
                e2 = e1; e1 = e;
                l2v = l1v; l2 = l1; l2n = l1n;
                l1v = litReq; l1 = litVal; l1n = litName;
            end
        end
    end

    // Compare process
    initial begin
        logic [13:0] got;
        int          seen;
        seen = 0;
        forever begin
            @(negedge clkIn);
            if (checkOn) begin
                got = {redOut, greenOut, blueOut, hSyncOut, vSyncOut};
                nTests++;
                if (got !== e2 || modeOut !== 2'(mMode)) begin
                    nFail++;
                    $display("FAIL model t=%0t: got rgbhv=%h mode=%0d, expected rgbhv=%h mode=%0d",
                             $time, got, modeOut, e2, mMode);
                end
                if (l2v) begin
                    nTests++;
                    if (got !== l2) begin
                        nFail++;
                        $display("FAIL %s: got rgbhv=%h, expected %h", l2n, got, l2);
                    end
                end
                if (dirSeq != seen) begin
                    seen = dirSeq;
                    nTests++;
                    if (dirKind == 1) begin
                        if (got !== 14'd0 || modeOut !== 2'd0) begin
                            nFail++;
                            $display("FAIL %s: got rgbhv=%h mode=%0d, expected all zero", dirName, got, modeOut);
                        end
                    end else if (modeOut !== 2'(dirMode)) begin
                        nFail++;
                        $display("FAIL %s: got mode=%0d, expected %0d", dirName, modeOut, dirMode);
                    end
                end
            end
        end
    end

    task automatic drive(input int h, input int v, input bit de, input bit hs, input bit vs, input bit mn);
        @(posedge clkIn);
        #1;
        hPosIn = 16'(h); vPosIn = 16'(v);
        isDisplayOnIn = de; isHSyncIn = hs; isVSyncIn = vs; modeNextIn = mn;
        litReq = 1'b0;
        if (h == 0 && v == 0 && !rstIn) fsCount++;
    endtask

    task automatic driveLit(input int h, input int v, input bit de, input bit hs, input bit vs,
                            input logic [11:0] rgb, input string name);
        drive(h, v, de, hs, vs, 1'b0);
        litReq = 1'b1; litVal = {rgb, hs, vs}; litName = name;
    endtask

    task automatic checkMode(input string name, input int m);
        dirKind = 0; dirMode = m; dirName = name; dirSeq++;
        @(negedge clkIn);
        #1;
    endtask

    task automatic checkZero(input string name);
        dirKind = 1; dirName = name; dirSeq++;
        @(negedge clkIn);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clkIn);
        #1;
        checkOn = 1'b1;
        checkZero("resetState");

        @(posedge clkIn);
        #1;
        rstIn = 1'b0;
        driveLit(0,   0, 1, 0, 0, 12'hFFF, "bar0_h0");
        driveLit(150, 0, 1, 1, 0, 12'hFF0, "bar1_h150");
        driveLit(799, 0, 1, 0, 1, 12'h000, "bar7_h799");
        driveLit(99,  0, 1, 0, 0, 12'hFFF, "bar0_h99");
        driveLit(100, 0, 1, 0, 0, 12'hFF0, "bar1_h100");
        driveLit(250, 0, 1, 0, 0, 12'h0FF, "bar2_h250");
        driveLit(450, 0, 1, 0, 0, 12'hF0F, "bar4_h450");
        driveLit(650, 0, 1, 0, 0, 12'h00F, "bar6_h650");
        driveLit(900, 0, 0, 1, 0, 12'h000, "blank_hsync_pulse");
        driveLit(901, 0, 0, 0, 0, 12'h000, "blank_hsync_end");

        // several requests inside one frame advance the mode once, at the next frame start
        drive(10, 5, 1, 0, 0, 1);
        drive(11, 5, 1, 0, 0, 0);
        drive(12, 5, 1, 0, 0, 1);
        drive(13, 5, 1, 0, 0, 1);
        drive(14, 5, 1, 0, 0, 0);
        checkMode("modeHeldMidFrame", 0);
        driveLit(0,  0,  1, 0, 0, 12'h000, "chk_0_0");
        driveLit(32, 0,  1, 0, 0, 12'hFFF, "chk_32_0");
        driveLit(32, 32, 1, 0, 0, 12'h000, "chk_32_32");
        driveLit(0,  32, 1, 0, 0, 12'hFFF, "chk_0_32");
        checkMode("modeAfterFs", 1);

        // request coinciding with frame start
        drive(0, 0, 1, 0, 0, 1);
        driveLit(64,   0,  1, 0, 0, 12'h111, "grad_64");
        driveLit(640,  10, 1, 0, 0, 12'hAAA, "grad_640");
        driveLit(959,  10, 1, 0, 0, 12'hEEE, "grad_959");
        driveLit(1000, 10, 1, 0, 0, 12'hFFF, "grad_sat");
        checkMode("fsCoincident", 2);

        drive(0, 0, 1, 0, 0, 1);
        driveLit(8,  8,  1, 0, 0, 12'hFFF, "box_corner_f4");
        driveLit(7,  8,  1, 0, 0, 12'h007, "box_left_out_f4");
        driveLit(23, 23, 1, 0, 0, 12'hFFF, "box_far_in_f4");
        driveLit(24, 23, 1, 0, 0, 12'h007, "box_right_out_f4");
        driveLit(23, 24, 1, 0, 0, 12'h007, "box_below_out_f4");
        checkMode("mode3", 3);

        drive(0, 0, 1, 0, 0, 1);
        drive(5, 5, 1, 0, 0, 0);
        checkMode("modeWrap", 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0, 1);
            drive(5, 5, 1, 1, 1, 0);
        end
        checkMode("mode3again", 3);

        // bounce run: probe around the box each frame
        while (fsCount < 400) begin
            drive(0, 0, 1, 0, 0, 0);
            if (fsCount == 292) begin
                driveLit(584, 584, 1, 0, 0, 12'hFFF, "box_f292_in");
                driveLit(583, 584, 1, 0, 0, 12'h007, "box_f292_out");
            end else if (fsCount == 392) begin
                driveLit(784, 386, 1, 0, 0, 12'hFFF, "box_f392_in");
                driveLit(783, 386, 1, 0, 0, 12'h007, "box_f392_out");
            end else if (fsCount == 400) begin
                driveLit(770, 370, 1, 0, 0, 12'hFFF, "box_f400_in");
                driveLit(769, 370, 1, 0, 0, 12'h007, "box_f400_out");
            end else begin
                drive(1, 0, 1, 0, 0, 0);
                drive(mBoxX, mBoxY, 1, 0, 0, 0);
                drive(mBoxX + 16, mBoxY, 1, 0, 0, 0);
                drive(mBoxX + 15, mBoxY + 16, 1, 0, 0, 0);
            end
        end

        // asynchronous reset in the middle of a mode-2 frame
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0, 1);
            drive(5, 5, 1, 0, 0, 0);
        end
        checkMode("mode2BeforeReset", 2);
        drive(300, 100, 1, 0, 0, 0);
        drive(301, 100, 1, 1, 1, 0);
        drive(302, 100, 1, 1, 1, 0);
        @(posedge clkIn);
        #2;
        rstIn = 1'b1;
        checkZero("asyncResetMidFrame");
        repeat (2) @(posedge clkIn);
        #1;
        rstIn   = 1'b0;
        fsCount = 0;
        driveLit(300, 101, 1, 0, 0, 12'h0F0, "postReset_bar3");
        checkMode("postResetMode", 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0, 1);
            drive(40, 40, 1, 0, 0, 0);
        end
        driveLit(6, 6, 1, 0, 0, 12'hFFF, "postReset_box_in");
        driveLit(5, 6, 1, 0, 0, 12'h007, "postReset_box_out");
        drive(1, 1, 1, 0, 0, 0);
        repeat (3) @(posedge clkIn);
        @(negedge clkIn);
        #1;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
